instr_phase_sequencer: RTL and testbench

- Upstream control stage of the register-selector datapath.
- Accepts the instruction byte stream from fetch and decodes the 32-bit stack-frame subset: push ebp, mov ebp,esp, sub esp,imm8, pop ebp, nop.
- Runs the 6-phase execution sequence and drives the phase strobes clock_3 and clock_5, plus select_1/select_2 and immediate_data, to the register selector.
- Owns eip.

---
 rtl/instr_phase_sequencer_pkg.sv | 52 +++++
 rtl/instr_phase_sequencer_decode.sv | 91 +++++++++
 rtl/instr_phase_sequencer.sv | 100 ++++++++++
 tb/tb_instr_phase_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_phase_sequencer_pkg.sv
// Shared opcodes, register-select codes and sequencer state encoding for the
// stack-frame instruction subset.
package instr_phase_sequencer_pkg;

    localparam logic [7:0] OP_PUSH_EBP   = 8'h55;
    localparam logic [7:0] OP_POP_EBP    = 8'h5D;
    localparam logic [7:0] OP_NOP        = 8'h90;
    localparam logic [7:0] OP_MOV        = 8'h89;
    localparam logic [7:0] MODRM_EBP_ESP = 8'hE5;
    localparam logic [7:0] OP_GRP1       = 8'h83;
    localparam logic [7:0] MODRM_SUB_ESP = 8'hEC;

    localparam logic [3:0] SEL_NONE    = 4'd0;
    localparam logic [3:0] SEL_PUSH_R1 = 4'd1;
    localparam logic [3:0] SEL_PUSH_R2 = 4'd1;
    localparam logic [3:0] SEL_POP_R1  = 4'd4;
    localparam logic [3:0] SEL_POP_R2  = 4'd3;
    localparam logic [3:0] SEL_MOV_R1  = 4'd2;
    localparam logic [3:0] SEL_MOV_R2  = 4'd4;
    localparam logic [3:0] SEL_SUB_R1  = 4'd3;
    localparam logic [3:0] SEL_SUB_R2  = 4'd2;

    typedef enum logic [3:0] {
        ST_FETCH0,
        ST_FETCH1,
        ST_FETCH2,
        ST_PH1,
        ST_PH2,
        ST_PH3,
        ST_PH4,
        ST_PH5,
        ST_PH6,
        ST_HALT
    } state_t;

    function automatic logic [5:0] phase_of(input state_t s);
        case (s)
            ST_PH1:  return 6'b000001;
            ST_PH2:  return 6'b000010;
            ST_PH3:  return 6'b000100;
            ST_PH4:  return 6'b001000;
            ST_PH5:  return 6'b010000;
            ST_PH6:  return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic is_fetch(input state_t s);
        return (s == ST_FETCH0) || (s == ST_FETCH1) || (s == ST_FETCH2);
    endfunction

endpackage

// File: rtl/instr_phase_sequencer_decode.sv
// Combinational decode: current state plus the byte on offer produce the next
// state, the select codes to load on PH1 entry, and the illegal flag.
module instr_decode
    import instr_phase_sequencer_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  state_t      state_i,
    input  logic [7:0]  byte_i,
    input  logic        xfer_i,
    input  logic [7:0]  op_i,
    output state_t      state_o,
    output logic        load_sel_o,
    output logic [3:0]  sel1_o,
    output logic [3:0]  sel2_o,
    output logic        load_imm_o,
    output logic        illegal_o
);

    logic bad;

    always_comb begin
        state_o    = state_i;
        load_sel_o = 1'b0;
        sel1_o     = SEL_NONE;
        sel2_o     = SEL_NONE;
        load_imm_o = 1'b0;
        illegal_o  = 1'b0;
        bad        = 1'b0;

        case (state_i)
            ST_FETCH0: begin
                if (xfer_i) begin
                    case (byte_i)
                        OP_PUSH_EBP: begin
                            state_o = ST_PH1; load_sel_o = 1'b1;
                            sel1_o  = SEL_PUSH_R1; sel2_o = SEL_PUSH_R2;
                        end
                        OP_POP_EBP: begin
                            state_o = ST_PH1; load_sel_o = 1'b1;
                            sel1_o  = SEL_POP_R1; sel2_o = SEL_POP_R2;
                        end
                        OP_NOP: begin
                            state_o = ST_PH1; load_sel_o = 1'b1;
                        end
                        OP_MOV, OP_GRP1: state_o = ST_FETCH1;
                        default:         bad = 1'b1;
                    endcase
                end
            end
            ST_FETCH1: begin
                // op_i holds the first byte, so the pair is judged as a whole
                if (xfer_i) begin
                    if (op_i == OP_MOV && byte_i == MODRM_EBP_ESP) begin
                        state_o = ST_PH1; load_sel_o = 1'b1;
                        sel1_o  = SEL_MOV_R1; sel2_o = SEL_MOV_R2;
                    end else if (op_i == OP_GRP1 && byte_i == MODRM_SUB_ESP) begin
                        state_o = ST_FETCH2;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            ST_FETCH2: begin
                if (xfer_i) begin
                    state_o    = ST_PH1; load_sel_o = 1'b1; load_imm_o = 1'b1;
                    sel1_o     = SEL_SUB_R1; sel2_o = SEL_SUB_R2;
                end
            end
            ST_PH1:  state_o = ST_PH2;
            ST_PH2:  state_o = ST_PH3;
            ST_PH3:  state_o = ST_PH4;
            ST_PH4:  state_o = ST_PH5;
            ST_PH5:  state_o = ST_PH6;
            ST_PH6:  state_o = ST_FETCH0;
            ST_HALT: state_o = ST_HALT;
            default: state_o = ST_FETCH0;
        endcase

        if (bad) begin
            illegal_o = 1'b1;
            if (HALT_ON_ILLEGAL) begin
                state_o = ST_HALT;
            end else begin
                state_o    = ST_PH1;
                load_sel_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_phase_sequencer.sv
// Fetch/decode front end of the register-selector datapath: consumes opcode
// bytes, owns eip, and sequences the six execution phases.
module instr_phase_sequencer
    import instr_phase_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_EIP       = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] eip,
    output logic [5:0]  phase,
    output logic        clock_3,
    output logic        clock_5,
    output logic [3:0]  select_1,
    output logic [3:0]  select_2,
    output logic [31:0] immediate_data,
    output logic        instr_done,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [31:0] eip_q;
    logic [7:0]  op_q;
    logic [3:0]  sel1_q, sel2_q, sel1_d, sel2_d;
    logic [31:0] imm_q;
    logic        ill_pend_q;
    logic [5:0]  phase_q;
    logic        done_q;
    logic        illegal_q;
    logic        xfer, load_sel, load_imm, dec_illegal;

    // Gated by reset so nothing is offered upstream until reset is released
    assign byte_ready = is_fetch(state_q) && !reset;
    assign xfer       = byte_valid && byte_ready;

    instr_decode #(
        .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
    ) u_decode (
        .state_i    (state_q),
        .byte_i     (byte_in),
        .xfer_i     (xfer),
        .op_i       (op_q),
        .state_o    (state_d),
        .load_sel_o (load_sel),
        .sel1_o     (sel1_d),
        .sel2_o     (sel2_d),
        .load_imm_o (load_imm),
        .illegal_o  (dec_illegal)
    );

    // Strobes are registered from the next state so they line up with state_q
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH0;
            eip_q      <= RESET_EIP;
            op_q       <= 8'h00;
            sel1_q     <= SEL_NONE;
            sel2_q     <= SEL_NONE;
            imm_q      <= 32'h0;
            ill_pend_q <= 1'b0;
            phase_q    <= 6'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                eip_q <= eip_q + 32'd1;
            end
            if (xfer && state_q == ST_FETCH0) begin
                op_q <= byte_in;
            end
            if (load_sel) begin
                sel1_q     <= sel1_d;
                sel2_q     <= sel2_d;
                ill_pend_q <= dec_illegal;
            end
            if (load_imm) begin
                imm_q <= {{24{byte_in[7]}}, byte_in};
            end
            phase_q   <= phase_of(state_d);
            done_q    <= (state_d == ST_PH6);
            illegal_q <= (state_d == ST_HALT) || (state_d == ST_PH6 && ill_pend_q);
        end
    end

    assign eip            = eip_q;
    assign phase          = phase_q;
    assign clock_3        = phase_q[2];
    assign clock_5        = phase_q[4];
    assign select_1       = sel1_q;
    assign select_2       = sel2_q;
    assign immediate_data = imm_q;
    assign instr_done     = done_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Bench for instr_phase_sequencer: three instances (halting, non-halting,
// non-halting with RESET_EIP at the top of the address space).
module tb_instr_phase_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byteIn [3];
    logic        byteValid [3];
    logic        byteReady [3];
    logic [31:0] eipO [3];
    logic [5:0]  phaseO [3];
    logic        clk3O [3];
    logic        clk5O [3];
    logic [3:0]  sel1O [3];
    logic [3:0]  sel2O [3];
    logic [31:0] immO [3];
    logic        doneO [3];
    logic        illegalO [3];

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;
    logic [31:0] modelEip [3];
    logic [31:0] modelImm [3];

    typedef struct {
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        ill;
        logic        immLoad;
        logic [31:0] imm;
    } expect_t;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        instr_phase_sequencer #(
            .RESET_EIP       ((g == 2) ? 32'hFFFF_FFFF : 32'h0000_0000),
            .HALT_ON_ILLEGAL ((g == 0) ? 1'b1 : 1'b0)
        ) dut (
            .clock          (clock),
            .reset          (reset),
            .byte_in        (byteIn[g]),
            .byte_valid     (byteValid[g]),
            .byte_ready     (byteReady[g]),
            .eip            (eipO[g]),
            .phase          (phaseO[g]),
            .clock_3        (clk3O[g]),
            .clock_5        (clk5O[g]),
            .select_1       (sel1O[g]),
            .select_2       (sel2O[g]),
            .immediate_data (immO[g]),
            .instr_done     (doneO[g]),
            .illegal        (illegalO[g])
        );
    end

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    function automatic logic [31:0] resetEipOf(input int d);
        return (d == 2) ? 32'hFFFF_FFFF : 32'h0000_0000;
    endfunction

    // Instruction table lookup: whole byte sequence -> expected selector outputs
    function automatic expect_t refDecode(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input int n);
        expect_t e;
        int v;
        e.s1 = 4'd0; e.s2 = 4'd0; e.ill = 1'b1; e.immLoad = 1'b0; e.imm = 32'h0;
        if (n == 1 && b0 == 8'h55) begin
            e.s1 = 4'd1; e.s2 = 4'd1; e.ill = 1'b0;
        end else if (n == 1 && b0 == 8'h5D) begin
            e.s1 = 4'd4; e.s2 = 4'd3; e.ill = 1'b0;
        end else if (n == 1 && b0 == 8'h90) begin
            e.ill = 1'b0;
        end else if (n == 2 && b0 == 8'h89 && b1 == 8'hE5) begin
            e.s1 = 4'd2; e.s2 = 4'd4; e.ill = 1'b0;
        end else if (n == 3 && b0 == 8'h83 && b1 == 8'hEC) begin
            e.s1 = 4'd3; e.s2 = 4'd2; e.ill = 1'b0; e.immLoad = 1'b1;
            v = (b2 < 8'd128) ? int'(b2) : int'(b2) - 256;
            e.imm = 32'(v);
        end
        return e;
    endfunction

    // Reset all instances and the reference state with them
    task automatic applyReset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            byteValid[d] = 1'b0;
            byteIn[d]    = 8'h00;
            modelEip[d]  = resetEipOf(d);
            modelImm[d]  = 32'h0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic sendByte(input int d, input logic [7:0] b, input string tag);
        int waited;
        waited = 0;
        byteIn[d]    = b;
        byteValid[d] = 1'b1;
        @(negedge clock);
        while (byteReady[d] !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (byteReady[d] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s byte_ready timeout: got %b required 1", tag, byteReady[d]);
        end
        @(posedge clock);
        #1;
        byteValid[d] = 1'b0;
    endtask

    task automatic runInstr(input int d, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n, input int gap, input string tag);
        expect_t    e;
        int         startCyc;
        int         elapsed;
        logic [7:0] bs [3];
        e = refDecode(b0, b1, b2, n);
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        @(posedge clock);
        #1;
        startCyc = cycleCnt;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clock);
                    checks++;
                    if (byteReady[d] !== 1'b1 || phaseO[d] !== 6'd0 || eipO[d] !== modelEip[d] + 32'(i)) begin
                        errors++;
                        $display("[TB] FAIL %s gap wait: ready=%b phase=%b eip=%h required ready=1 phase=0 eip=%h",
                                 tag, byteReady[d], phaseO[d], eipO[d], modelEip[d] + 32'(i));
                    end
                    @(posedge clock);
                    #1;
                end
            end
            sendByte(d, bs[i], tag);
        end
        modelEip[d] = modelEip[d] + 32'(n);
        if (e.immLoad) modelImm[d] = e.imm;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (phaseO[d] !== 6'(1 << k)) begin
                errors++;
                $display("[TB] FAIL %s phase PH%0d: got %b required %b", tag, k + 1, phaseO[d], 6'(1 << k));
            end
            checks++;
            if (clk3O[d] !== (k == 2) || clk5O[d] !== (k == 4)) begin
                errors++;
                $display("[TB] FAIL %s strobes PH%0d: got clock_3=%b clock_5=%b required %b %b",
                         tag, k + 1, clk3O[d], clk5O[d], (k == 2), (k == 4));
            end
            checks++;
            if (byteReady[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s byte_ready PH%0d: got %b required 0", tag, k + 1, byteReady[d]);
            end
            checks++;
            if (sel1O[d] !== e.s1 || sel2O[d] !== e.s2) begin
                errors++;
                $display("[TB] FAIL %s selects PH%0d: got %0d/%0d required %0d/%0d",
                         tag, k + 1, sel1O[d], sel2O[d], e.s1, e.s2);
            end
            checks++;
            if (immO[d] !== modelImm[d]) begin
                errors++;
                $display("[TB] FAIL %s immediate PH%0d: got %h required %h", tag, k + 1, immO[d], modelImm[d]);
            end
            checks++;
            if (doneO[d] !== (k == 5) || illegalO[d] !== (k == 5 && e.ill)) begin
                errors++;
                $display("[TB] FAIL %s done/illegal PH%0d: got %b/%b required %b/%b",
                         tag, k + 1, doneO[d], illegalO[d], (k == 5), (k == 5 && e.ill));
            end
            checks++;
            if (eipO[d] !== modelEip[d]) begin
                errors++;
                $display("[TB] FAIL %s eip PH%0d: got %h required %h", tag, k + 1, eipO[d], modelEip[d]);
            end
        end
        elapsed = cycleCnt - startCyc + 1;
        checks++;
        if (elapsed != n + gap * (n - 1) + 6) begin
            errors++;
            $display("[TB] FAIL %s cycle count: got %0d required %0d", tag, elapsed, n + gap * (n - 1) + 6);
        end
    endtask

    task automatic test_reset();
        applyReset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (eipO[d] !== resetEipOf(d) || phaseO[d] !== 6'd0 || sel1O[d] !== 4'd0 || sel2O[d] !== 4'd0
                || immO[d] !== 32'h0 || doneO[d] !== 1'b0 || illegalO[d] !== 1'b0 || byteReady[d] !== 1'b0
                || clk3O[d] !== 1'b0 || clk5O[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset state dut%0d: eip=%h phase=%b sel=%0d/%0d imm=%h done=%b ill=%b ready=%b required eip=%h rest 0",
                         d, eipO[d], phaseO[d], sel1O[d], sel2O[d], immO[d], doneO[d], illegalO[d], byteReady[d], resetEipOf(d));
            end
        end
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (byteReady[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset release dut%0d: byte_ready=%b required 1", d, byteReady[d]);
            end
        end
    endtask

    task automatic test_push();
        runInstr(0, 8'h55, 8'h00, 8'h00, 1, 0, "push");
        checks++;
        if (eipO[0] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL push eip: got %h required 00000001", eipO[0]);
        end
    endtask

    task automatic test_sub_imm();
        runInstr(0, 8'h83, 8'hEC, 8'hF0, 3, 0, "sub_F0");
        checks++;
        if (immO[0] !== 32'hFFFF_FFF0) begin
            errors++;
            $display("[TB] FAIL sub_F0 imm: got %h required fffffff0", immO[0]);
        end
        runInstr(0, 8'h83, 8'hEC, 8'h7F, 3, 0, "sub_7F");
        runInstr(0, 8'h55, 8'h00, 8'h00, 1, 0, "push_keeps_imm");
    endtask

    task automatic test_gap();
        runInstr(0, 8'h89, 8'hE5, 8'h00, 2, 3, "mov_gap");
    endtask

    task automatic test_halt();
        @(posedge clock);
        #1;
        sendByte(0, 8'h0F, "halt");
        modelEip[0] = modelEip[0] + 32'd1;
        byteIn[0]    = 8'h55;
        byteValid[0] = 1'b1;
        repeat (6) begin
            @(negedge clock);
            checks++;
            if (illegalO[0] !== 1'b1 || byteReady[0] !== 1'b0 || phaseO[0] !== 6'd0
                || eipO[0] !== modelEip[0] || doneO[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt hold: ill=%b ready=%b phase=%b eip=%h done=%b required 1 0 0 %h 0",
                         illegalO[0], byteReady[0], phaseO[0], eipO[0], doneO[0], modelEip[0]);
            end
        end
        applyReset();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (eipO[0] !== 32'h0 || illegalO[0] !== 1'b0 || byteReady[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt recovery: eip=%h ill=%b ready=%b required 0 0 1", eipO[0], illegalO[0], byteReady[0]);
        end
        runInstr(0, 8'h90, 8'h00, 8'h00, 1, 0, "after_halt");
    endtask

    task automatic test_illegal_continue();
        runInstr(1, 8'h0F, 8'h00, 8'h00, 1, 0, "ill_0F");
        runInstr(1, 8'h5D, 8'h00, 8'h00, 1, 0, "pop_after_ill");
        runInstr(1, 8'h89, 8'h12, 8'h00, 2, 1, "ill_mov_pair");
    endtask

    task automatic test_wrap();
        runInstr(2, 8'h90, 8'h00, 8'h00, 1, 0, "wrap");
        checks++;
        if (eipO[2] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap eip: got %h required 00000000", eipO[2]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock);
        #1;
        sendByte(0, 8'h55, "rst_mid");
        repeat (3) @(negedge clock);
        checks++;
        if (clk3O[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid PH3 strobe: got %b required 1", clk3O[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (phaseO[0] !== 6'd0 || clk3O[0] !== 1'b0 || eipO[0] !== 32'h0 || doneO[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid async: phase=%b clock_3=%b eip=%h done=%b required 0 0 0 0",
                     phaseO[0], clk3O[0], eipO[0], doneO[0]);
        end
        applyReset();
        reset = 1'b0;
        runInstr(0, 8'h5D, 8'h00, 8'h00, 1, 0, "after_rst_mid");
    endtask

    task automatic test_random();
        logic [7:0] b0, b1, b2;
        int n, kind, gap;
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 6));
            gap  = int'($urandom_range(0, 2));
            b1 = 8'h00; b2 = 8'h00; n = 1;
            case (kind)
                0: b0 = 8'h55;
                1: b0 = 8'h5D;
                2: b0 = 8'h90;
                3: begin b0 = 8'h89; b1 = 8'hE5; n = 2; end
                4: begin b0 = 8'h83; b1 = 8'hEC; b2 = 8'($urandom); n = 3; end
                5: begin
                    b0 = 8'($urandom);
                    while (b0 == 8'h55 || b0 == 8'h5D || b0 == 8'h90 || b0 == 8'h89 || b0 == 8'h83)
                        b0 = 8'($urandom);
                end
                default: begin
                    b0 = ($urandom_range(0, 1) == 0) ? 8'h89 : 8'h83;
                    b1 = 8'($urandom);
                    if ((b0 == 8'h89 && b1 == 8'hE5) || (b0 == 8'h83 && b1 == 8'hEC)) b1 = b1 ^ 8'h01;
                    n = 2;
                end
            endcase
            runInstr(1, b0, b1, b2, n, gap, "random");
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_sub_imm();
        test_gap();
        test_illegal_continue();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
